demlen_4bit: RTL and testbench
==============================

DEMLEN_4BIT -- requirements
Module: demlen_4bit

Interface
REQ-001 Parameter DIV, default 1, prescale ratio: OUT advances once per DIV enabled rising edges of Clk; legal range 1..65535.
REQ-002 Parameter MAXVAL, default 15, terminal count of OUT; legal range 1..15.
REQ-003 Port Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  asynchronous, active-high reset.
REQ-005 Port OUT  output  4  current count value, driven directly from a register.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-high.

Function
REQ-007 The block SHALL contain a 16-bit prescaler register PS and a 4-bit count register driving OUT.
REQ-008 On each rising Clk edge with RST low, if PS == DIV-1, PS SHALL load 0 and the count SHALL advance; otherwise PS SHALL increment by 1 and OUT SHALL hold.
REQ-009 Advance rule: if OUT < MAXVAL, OUT SHALL become OUT+1, with 4-bit arithmetic.
REQ-010 Advance at OUT == MAXVAL SHALL wrap OUT to 0 when DEMLEN4BIT_SAT_EN is undefined (REQ-016/017).
REQ-011 With DIV=1, OUT SHALL increment on every rising edge, with one-edge latency and no combinational path from inputs to OUT.
REQ-012 After RST deasserts, the first advance SHALL occur on the DIV-th rising edge sampled with RST low.
REQ-013 If OUT holds a value above MAXVAL, an advance SHALL load 0.

Reset
REQ-014 While RST is high, OUT SHALL be 0 and PS SHALL be 0 immediately, independent of Clk, and SHALL stay 0 for as long as RST is high.
REQ-015 RST asserted mid-count, including mid-prescale, SHALL discard all progress; the count restarts from 0 with PS = 0.

Configuration
REQ-016 Macro DEMLEN4BIT_SAT_EN undefined (default): at OUT == MAXVAL an advance SHALL wrap OUT to 0.
REQ-017 Macro DEMLEN4BIT_SAT_EN defined: at OUT == MAXVAL an advance SHALL leave OUT at MAXVAL and PS SHALL keep cycling; only RST returns OUT to 0.

Verification
REQ-018 RST=1 asserted between edges with Clk toggling -> OUT=0 immediately and stays 0 across 10 edges.
REQ-019 DIV=1, MAXVAL=15, RST released -> OUT reads 1,2,...,15,0,1 on successive rising edges.
REQ-020 DIV=3, RST released -> OUT=1 after edge 3, 2 after edge 6, unchanged on the other edges.
REQ-021 MAXVAL=9, DIV=1 -> OUT sequence 0..9 then 0; with DEMLEN4BIT_SAT_EN defined, OUT holds 9 for 5 further edges.
REQ-022 RST pulsed high for 2 ns while OUT=7 and PS mid-count -> OUT=0 at once; with DIV=1 the next edge after release gives OUT=1.

Source files
------------

// File: rtl/demlen_4bit.sv
// Prescaled 4-bit counter: OUT advances once every DIV clocks and wraps after MAXVAL.
// Define DEMLEN4BIT_SAT_EN to saturate at MAXVAL instead of wrapping.
module demlen_4bit #(
  parameter int unsigned DIV    = 1,
  parameter int unsigned MAXVAL = 15
) (
  input  logic       Clk,
  input  logic       RST,
  output logic [3:0] OUT
);

  localparam logic [15:0] PsLast = 16'(DIV - 1);
  localparam logic [3:0]  MaxVal = 4'(MAXVAL);

  logic [15:0] ps_q, ps_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    ps_d  = ps_q + 16'd1;
    cnt_d = cnt_q;
    if (ps_q == PsLast) begin
      ps_d = '0;
      if (cnt_q < MaxVal) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
`ifdef DEMLEN4BIT_SAT_EN
        // Hold at the terminal count; an out-of-range value still recovers to 0.
        cnt_d = (cnt_q == MaxVal) ? cnt_q : 4'd0;
`else
        cnt_d = 4'd0;
`endif
      end
    end
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      ps_q  <= '0;
      cnt_q <= '0;
    end else begin
      ps_q  <= ps_d;
      cnt_q <= cnt_d;
    end
  end

  assign OUT = cnt_q;

endmodule

// File: tb/tb_demlen_4bit.sv
// Scoreboard bench for demlen_4bit: three parameterisations share one clock and reset;
// expected counts come from an edge-count model.
module tb_demlen_4bit;

  logic       Clk = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] out_a, out_b, out_c;

  int checks   = 0;
  int failures = 0;
  int n        = 0;  // enabled rising edges since last reset release

  logic [3:0] q_a[$], q_b[$], q_c[$];

  always #5 Clk = ~Clk;

  demlen_4bit #(.DIV(1), .MAXVAL(15)) u_a (.Clk(Clk), .RST(RST), .OUT(out_a));
  demlen_4bit #(.DIV(3), .MAXVAL(15)) u_b (.Clk(Clk), .RST(RST), .OUT(out_b));
  demlen_4bit #(.DIV(1), .MAXVAL(9))  u_c (.Clk(Clk), .RST(RST), .OUT(out_c));

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model(input int edges, input int div, input int maxval);
    int adv;
    adv = edges / div;
`ifdef DEMLEN4BIT_SAT_EN
    return 4'((adv > maxval) ? maxval : adv);
`else
    return 4'(adv % (maxval + 1));
`endif
  endfunction

  // Push expectations for the coming edge, clock it, then pop and compare.
  task automatic step(input string tag);
    q_a.push_back(RST ? 4'd0 : model(n + 1, 1, 15));
    q_b.push_back(RST ? 4'd0 : model(n + 1, 3, 15));
    q_c.push_back(RST ? 4'd0 : model(n + 1, 1, 9));
    @(posedge Clk);
    if (!RST) n++;
    #1;
    check($sformatf("%s_d1m15_e%0d", tag, n), out_a, q_a.pop_front());
    check($sformatf("%s_d3m15_e%0d", tag, n), out_b, q_b.pop_front());
    check($sformatf("%s_d1m9_e%0d", tag, n), out_c, q_c.pop_front());
  endtask

  initial begin
    // Assert reset between edges and check it takes effect without a clock edge.
    @(posedge Clk);
    #3;
    RST = 1'b1;
    #1;
    check("rst_async_a", out_a, 4'd0);
    check("rst_async_b", out_b, 4'd0);
    check("rst_async_c", out_c, 4'd0);
    for (int i = 0; i < 10; i++) step("rst_hold");

    #2;
    RST = 1'b0;
    n   = 0;
    for (int i = 0; i < 40; i++) step("run");

    // Restart and bring the DIV=1 counter to 7 with the DIV=3 prescaler mid-count.
    #2;
    RST = 1'b1;
    #1;
    check("rst_restart_a", out_a, 4'd0);
    #1;
    RST = 1'b0;
    n   = 0;
    for (int i = 0; i < 7; i++) step("pre");
    check("at7_a", out_a, 4'd7);

    #2;
    RST = 1'b1;
    #1;
    check("pulse_a", out_a, 4'd0);
    check("pulse_b", out_b, 4'd0);
    check("pulse_c", out_c, 4'd0);
    #1;
    RST = 1'b0;
    n   = 0;
    step("post");
    check("post_first_a", out_a, 4'd1);
    for (int i = 0; i < 14; i++) step("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
